report_arb: RTL and testbench

REPORT_ARB -- requirements
Module: report_arb

---
 rtl/report_arb_pkg.sv | 23 ++
 rtl/report_tbucket.sv | 60 ++++++
 rtl/report_arb.sv | 166 ++++++++++++++++
 tb/tb_report_arb.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/report_arb_pkg.sv
// report_arb_pkg -- shared datapath constants and types for the report
// arbiter: bus word width, header codes and the arbiter FSM encoding.
package report_arb_pkg;

    localparam int DATA_W    = 134;
    localparam int PAYLOAD_W = 132;
    localparam int HDR_MSB   = DATA_W - 1;
    localparam int HDR_LSB   = DATA_W - 2;

    localparam logic [1:0] HDR_HEAD = 2'b01;
    localparam logic [1:0] HDR_BODY = 2'b11;
    localparam logic [1:0] HDR_TAIL = 2'b10;

    localparam logic PORT_UD = 1'b0;
    localparam logic PORT_LR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_HEAD = 2'd1,
        ST_XFER      = 2'd2
    } arb_state_e;

endpackage

// File: rtl/report_tbucket.sv
// report_tbucket -- rate limiter for the lreport port.
//   clk, rst_n   : clock, async active-low reset
//   para         : cycles per token; 0 = unlimited (bucket held full)
//   consume      : deduct one token this cycle
//   token_avail  : at least one token available (or unlimited)
// The period in use is re-sampled from para only at a counter wrap, so a
// new rate starts cleanly on a period boundary.
module report_tbucket
    import report_arb_pkg::*;
#(
    parameter int TB_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] para,
    input  logic        consume,
    output logic        token_avail
);

    localparam logic [7:0] TOK_MAX = 8'(TB_DEPTH);

    logic [31:0] period_q;
    logic [31:0] cycle_cnt;
    logic [7:0]  tokens_q;
    logic [7:0]  tokens_d;
    logic        wrap;

    assign wrap        = (period_q != 32'd0) && (cycle_cnt == period_q - 32'd1);
    assign token_avail = (period_q == 32'd0) || (tokens_q != 8'd0);

    // A refill and a deduction in the same cycle cancel, even when full.
    always_comb begin
        tokens_d = tokens_q;
        if (wrap && !consume && (tokens_q < TOK_MAX))
            tokens_d = tokens_q + 8'd1;
        else if (!wrap && consume && (tokens_q != 8'd0))
            tokens_d = tokens_q - 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q  <= 32'd0;
            cycle_cnt <= 32'd0;
            tokens_q  <= TOK_MAX;
        end else if (period_q == 32'd0) begin
            period_q  <= para;
            cycle_cnt <= 32'd0;
            tokens_q  <= TOK_MAX;
        end else begin
            if (wrap) begin
                cycle_cnt <= 32'd0;
                period_q  <= para;
            end else begin
                cycle_cnt <= cycle_cnt + 32'd1;
            end
            tokens_q <= tokens_d;
        end
    end

endmodule

// File: rtl/report_arb.sv
// report_arb -- merges whole packets from the update/forward port (0) and
// the lreport port (1) onto one output bus.
//   clk, rst_n                 : clock, async active-low reset
//   ud_req / ud_gnt / ud_*     : port 0 request, grant pulse, packet bus
//   lr_req / lr_gnt / lr_*     : port 1 request, grant pulse, packet bus
//   out_*                      : merged packet bus, registered, 1-cycle latency
//   out_ready                  : downstream can take a whole packet
//   token_bucket_para          : port 1 cycles per token (0 = unlimited)
//   timeout_cnt                : saturating count of revoked grants
//
// state        | meaning
// ST_IDLE      | no packet owned; arbitrate when out_ready
// ST_WAIT_HEAD | grant issued, waiting up to WAIT_TO cycles for head word
// ST_XFER      | forwarding selected port until its tail word
module report_arb
    import report_arb_pkg::*;
#(
    parameter int TB_DEPTH = 8,
    parameter int WAIT_TO  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ud_req,
    output logic              ud_gnt,
    input  logic              ud_data_wr,
    input  logic [DATA_W-1:0] ud_data,
    input  logic              ud_data_valid,
    input  logic              ud_data_valid_wr,
    input  logic              lr_req,
    output logic              lr_gnt,
    input  logic              lr_data_wr,
    input  logic [DATA_W-1:0] lr_data,
    input  logic              lr_data_valid,
    input  logic              lr_data_valid_wr,
    output logic              out_data_wr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_data_valid,
    output logic              out_data_valid_wr,
    input  logic              out_ready,
    input  logic [31:0]       token_bucket_para,
    output logic [15:0]       timeout_cnt
);

    localparam logic [15:0] WAIT_LOAD = 16'(WAIT_TO);

    arb_state_e        state_q, state_d;
    logic              sel_q, sel_d;
    logic              rr_q, rr_d;
    logic [15:0]       wait_q, wait_d;
    logic              ud_gnt_d, lr_gnt_d;
    logic              fwd;
    logic              timeout_hit;
    logic              consume;
    logic              token_avail;
    logic              ud_elig, lr_elig, pick;

    logic              sel_wr;
    logic [DATA_W-1:0] sel_data;
    logic              sel_valid;
    logic              sel_valid_wr;
    logic [1:0]        sel_hdr;

    assign sel_wr       = sel_q ? lr_data_wr       : ud_data_wr;
    assign sel_data     = sel_q ? lr_data          : ud_data;
    assign sel_valid    = sel_q ? lr_data_valid    : ud_data_valid;
    assign sel_valid_wr = sel_q ? lr_data_valid_wr : ud_data_valid_wr;
    assign sel_hdr      = sel_data[HDR_MSB:HDR_LSB];

    report_tbucket #(
        .TB_DEPTH (TB_DEPTH)
    ) u_tbucket (
        .clk         (clk),
        .rst_n       (rst_n),
        .para        (token_bucket_para),
        .consume     (consume),
        .token_avail (token_avail)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= PORT_UD;
            rr_q    <= PORT_UD;
            wait_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_d        = rr_q;
        wait_d      = wait_q;
        ud_gnt_d    = 1'b0;
        lr_gnt_d    = 1'b0;
        fwd         = 1'b0;
        timeout_hit = 1'b0;
        consume     = 1'b0;
        ud_elig     = ud_req;
        lr_elig     = lr_req && token_avail;
        pick        = PORT_UD;

        case (state_q)
            ST_IDLE: begin
                if (out_ready && (ud_elig || lr_elig)) begin
                    pick     = (ud_elig && lr_elig) ? rr_q : lr_elig;
                    sel_d    = pick;
                    ud_gnt_d = (pick == PORT_UD);
                    lr_gnt_d = (pick == PORT_LR);
                    wait_d   = WAIT_LOAD;
                    state_d  = ST_WAIT_HEAD;
                end
            end
            ST_WAIT_HEAD: begin
                if (sel_wr && (sel_hdr == HDR_HEAD)) begin
                    fwd     = 1'b1;
                    // The token is charged once the granted source actually
                    // starts its packet, so a revoked grant leaves it intact.
                    consume = (sel_q == PORT_LR);
                    state_d = ST_XFER;
                end else if (wait_q <= 16'd1) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    wait_d = wait_q - 16'd1;
                end
            end
            ST_XFER: begin
                if (sel_wr) begin
                    fwd = 1'b1;
                    if (sel_hdr == HDR_TAIL) begin
                        rr_d    = ~sel_q;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ud_gnt            <= 1'b0;
            lr_gnt            <= 1'b0;
            out_data_wr       <= 1'b0;
            out_data          <= '0;
            out_data_valid    <= 1'b0;
            out_data_valid_wr <= 1'b0;
            timeout_cnt       <= 16'd0;
        end else begin
            ud_gnt            <= ud_gnt_d;
            lr_gnt            <= lr_gnt_d;
            out_data_wr       <= fwd;
            out_data          <= fwd ? sel_data : '0;
            out_data_valid    <= fwd && sel_valid;
            out_data_valid_wr <= fwd && sel_valid_wr;
            if (timeout_hit && (timeout_cnt != 16'hFFFF))
                timeout_cnt <= timeout_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_report_arb.sv
module tb_report_arb;
    import report_arb_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              ud_req, ud_gnt, ud_data_wr, ud_data_valid, ud_data_valid_wr;
    logic [DATA_W-1:0] ud_data;
    logic              lr_req, lr_gnt, lr_data_wr, lr_data_valid, lr_data_valid_wr;
    logic [DATA_W-1:0] lr_data;
    logic              out_data_wr, out_data_valid, out_data_valid_wr, out_ready;
    logic [DATA_W-1:0] out_data;
    logic [31:0]       token_bucket_para;
    logic [15:0]       timeout_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    report_arb #(.TB_DEPTH(2), .WAIT_TO(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ud_req(ud_req), .ud_gnt(ud_gnt), .ud_data_wr(ud_data_wr), .ud_data(ud_data),
        .ud_data_valid(ud_data_valid), .ud_data_valid_wr(ud_data_valid_wr),
        .lr_req(lr_req), .lr_gnt(lr_gnt), .lr_data_wr(lr_data_wr), .lr_data(lr_data),
        .lr_data_valid(lr_data_valid), .lr_data_valid_wr(lr_data_valid_wr),
        .out_data_wr(out_data_wr), .out_data(out_data), .out_data_valid(out_data_valid),
        .out_data_valid_wr(out_data_valid_wr), .out_ready(out_ready),
        .token_bucket_para(token_bucket_para), .timeout_cnt(timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int         port;
        logic       wr;
        logic [1:0] hdr;
        int         idx;
        logic       v;
        logic       vw;
        logic       exp_wr;
        logic       exp_v;
        logic       exp_vw;
    } vec_t;

    vec_t vecs[10];

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [DATA_W-1:0] act,
                              input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk_word(input logic [1:0] hdr, input int port,
                                                  input int idx);
        logic [31:0] tag;
        tag = 32'(port * 4096 + idx + 32'h5A00);
        return {hdr, 4'hC, 96'h0, tag};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        ud_data_wr = 1'b0; ud_data = '0; ud_data_valid = 1'b0; ud_data_valid_wr = 1'b0;
        lr_data_wr = 1'b0; lr_data = '0; lr_data_valid = 1'b0; lr_data_valid_wr = 1'b0;
    endtask

    task automatic drive_word(input int port, input logic wr, input logic [DATA_W-1:0] d,
                              input logic v, input logic vw);
        bus_idle();
        if (port == 0) begin
            ud_data_wr = wr; ud_data = d; ud_data_valid = v; ud_data_valid_wr = vw;
        end else begin
            lr_data_wr = wr; lr_data = d; lr_data_valid = v; lr_data_valid_wr = vw;
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        ud_req = 1'b0;
        lr_req = 1'b0;
        bus_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_gnt(output int port, output int at_cyc, input int budget);
        port   = -1;
        at_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (ud_gnt || lr_gnt) begin
                port   = lr_gnt ? 1 : 0;
                at_cyc = cyc;
                check1("gnt_onehot", ud_gnt & lr_gnt, 1'b0);
                break;
            end
        end
    endtask

    task automatic send_pkt(input int port, input int nwords, input bit drop_ready);
        logic [1:0]        hdr;
        logic [DATA_W-1:0] w;
        logic              v, vw;
        for (int i = 0; i < nwords; i++) begin
            hdr = (i == 0) ? HDR_HEAD : ((i == nwords - 1) ? HDR_TAIL : HDR_BODY);
            w   = mk_word(hdr, port, i);
            vw  = (i == nwords - 1);
            v   = vw && (port == 0);
            drive_word(port, 1'b1, w, v, vw);
            if (drop_ready && i == 1) out_ready = 1'b0;
            tick();
            check1("pkt_wr", out_data_wr, 1'b1);
            check_word("pkt_data", out_data, w);
            check1("pkt_valid", out_data_valid, v);
            check1("pkt_valid_wr", out_data_valid_wr, vw);
            if (i == 0) check1("gnt_single_pulse", ud_gnt | lr_gnt, 1'b0);
        end
        bus_idle();
    endtask

    int p, gc;
    int g[5];
    int exp_order[4];

    initial begin
        vecs[0] = '{0, 1'b1, HDR_BODY, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1, 1'b1, HDR_HEAD, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{0, 1'b1, HDR_TAIL, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{0, 1'b1, HDR_HEAD, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{0, 1'b0, HDR_BODY, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1, 1'b1, HDR_BODY, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{0, 1'b1, HDR_BODY, 6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{0, 1'b1, HDR_BODY, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{0, 1'b1, HDR_TAIL, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{0, 1'b1, HDR_HEAD, 9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_order = '{0, 1, 0, 1};

        out_ready         = 1'b1;
        token_bucket_para = 32'd0;
        do_reset();

        // Reset values
        check1("rst_ud_gnt", ud_gnt, 1'b0);
        check1("rst_lr_gnt", lr_gnt, 1'b0);
        check1("rst_out_wr", out_data_wr, 1'b0);
        check_word("rst_out_data", out_data, '0);
        check1("rst_out_valid", out_data_valid, 1'b0);
        check1("rst_out_valid_wr", out_data_valid_wr, 1'b0);
        check16("rst_timeout_cnt", timeout_cnt, 16'd0);

        // Port 0 packet with ignored words, bubble and 1-cycle latency
        ud_req = 1'b1;
        wait_gnt(p, gc, 3);
        check_int("vec_grant_port", p, 0);
        ud_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_word(vecs[i].port, vecs[i].wr, mk_word(vecs[i].hdr, vecs[i].port, vecs[i].idx),
                       vecs[i].v, vecs[i].vw);
            tick();
            check1($sformatf("vec%0d_wr", i), out_data_wr, vecs[i].exp_wr);
            check_word($sformatf("vec%0d_data", i), out_data,
                       vecs[i].exp_wr ? mk_word(vecs[i].hdr, vecs[i].port, vecs[i].idx) : '0);
            check1($sformatf("vec%0d_valid", i), out_data_valid, vecs[i].exp_v);
            check1($sformatf("vec%0d_valid_wr", i), out_data_valid_wr, vecs[i].exp_vw);
            check1($sformatf("vec%0d_no_gnt", i), ud_gnt | lr_gnt, 1'b0);
        end
        bus_idle();

        // Round-robin with both requests held, unlimited port 1
        do_reset();
        ud_req = 1'b1;
        lr_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(p, gc, 5);
            check_int($sformatf("rr_order%0d", k), p, exp_order[k]);
            if (p >= 0) send_pkt(p, 3, 1'b0);
        end
        ud_req = 1'b0;
        lr_req = 1'b0;

        // out_ready gating in IDLE only
        out_ready = 1'b0;
        ud_req    = 1'b1;
        lr_req    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check1("no_gnt_not_ready", ud_gnt | lr_gnt, 1'b0);
        end
        out_ready = 1'b1;
        wait_gnt(p, gc, 3);
        check_int("ready_grant_port", p, 0);
        if (p >= 0) send_pkt(p, 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check1("no_gnt_after_ready_drop", ud_gnt | lr_gnt, 1'b0);
        end
        ud_req    = 1'b0;
        lr_req    = 1'b0;
        out_ready = 1'b1;
        tick();

        // Token bucket rate: TB_DEPTH=2, para=10
        token_bucket_para = 32'd10;
        lr_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(p, gc, 25);
            g[k] = gc;
            check_int($sformatf("tb_grant_port%0d", k), p, 1);
            if (p >= 0) send_pkt(p, 2, 1'b0);
        end
        lr_req = 1'b0;
        check_int("tb_gap01", g[1] - g[0], 3);
        check_int("tb_gap12", g[2] - g[1], 8);
        check_int("tb_gap23", g[3] - g[2], 10);
        check_int("tb_gap34", g[4] - g[3], 10);

        // Grant timeout on port 1, token retained
        token_bucket_para = 32'd1000;
        do_reset();
        lr_req = 1'b1;
        wait_gnt(p, gc, 3);
        check_int("to_grant_port", p, 1);
        for (int i = 1; i <= 15; i++) begin
            tick();
            check1("to_no_early_regnt", lr_gnt, 1'b0);
        end
        check16("to_cnt_before", timeout_cnt, 16'd0);
        tick();
        check16("to_cnt_after", timeout_cnt, 16'd1);
        check1("to_no_gnt_at_timeout", lr_gnt, 1'b0);
        wait_gnt(p, gc, 2);
        check_int("to_regrant_from_idle", p, 1);
        if (p >= 0) send_pkt(p, 2, 1'b0);
        wait_gnt(p, gc, 2);
        check_int("to_token_retained", p, 1);
        if (p >= 0) send_pkt(p, 2, 1'b0);
        wait_gnt(p, gc, 30);
        check_int("to_bucket_empty", p, -1);
        lr_req = 1'b0;
        tick();

        // Reset in the middle of a port-0 transfer
        ud_req = 1'b1;
        wait_gnt(p, gc, 3);
        check_int("mr_first_grant", p, 0);
        if (p >= 0) send_pkt(p, 2, 1'b0);
        wait_gnt(p, gc, 3);
        check_int("mr_second_grant", p, 0);
        ud_req = 1'b0;
        drive_word(0, 1'b1, mk_word(HDR_HEAD, 0, 20), 1'b0, 1'b0);
        tick();
        check1("mr_head_fwd", out_data_wr, 1'b1);
        drive_word(0, 1'b1, mk_word(HDR_BODY, 0, 21), 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check1("mr_rst_ud_gnt", ud_gnt, 1'b0);
        check1("mr_rst_lr_gnt", lr_gnt, 1'b0);
        check1("mr_rst_out_wr", out_data_wr, 1'b0);
        check_word("mr_rst_out_data", out_data, '0);
        check1("mr_rst_out_valid", out_data_valid, 1'b0);
        check1("mr_rst_out_valid_wr", out_data_valid_wr, 1'b0);
        check16("mr_rst_timeout_cnt", timeout_cnt, 16'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check1("mr_no_stale_body", out_data_wr, 1'b0);
        drive_word(0, 1'b1, mk_word(HDR_TAIL, 0, 22), 1'b1, 1'b1);
        tick();
        check1("mr_no_stale_tail", out_data_wr, 1'b0);
        bus_idle();
        ud_req = 1'b1;
        lr_req = 1'b1;
        wait_gnt(p, gc, 3);
        check_int("mr_rr_reset_port0", p, 0);
        if (p >= 0) send_pkt(p, 2, 1'b0);
        wait_gnt(p, gc, 3);
        check_int("mr_tokens_refilled", p, 1);
        if (p >= 0) send_pkt(p, 2, 1'b0);
        ud_req = 1'b0;
        lr_req = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
